// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, status-bit and driver-state definitions for the
// ALU operand driver and its response FIFO.
package alu_pkg;

    // Default interface widths (opcode, operand/result).
    localparam int ALU_N = 2;
    localparam int ALU_M = 8;

    // Status vector is 4 bits wide; these name the bit positions.
    localparam int ALU_ST_W = 4;
    localparam int ST_ZERO  = 0;
    localparam int ST_NEG   = 1;
    localparam int ST_CARRY = 2;
    localparam int ST_OVF   = 3;

    // Latency counter is sized for the largest legal LAT (15).
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_A_SUB_2B  = 2'b00,
        OP_A_LT_B    = 2'b01,
        OP_SUM_BIT_B = 2'b10,
        OP_U2_TO_ZM  = 2'b11
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } drv_state_e;

endpackage

// File: rtl/alu_resp_fifo.sv
// alu_resp_fifo: synchronous FIFO (power-of-two DEPTH) holding captured
// {result, status} responses. Head reads as zero while empty.
module alu_resp_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic                        push_en;
    logic                        pop_en;

    assign o_empty = (count == '0);
    assign o_full  = (count == CW'(DEPTH));
    assign o_count = count;
    // A pop frees a slot in the same edge, so a push at full is legal then.
    assign pop_en  = i_pop && !o_empty;
    assign push_en = i_push && (!o_full || pop_en);
    assign o_head  = o_empty ? '0 : mem[rd_ptr];

    // Storage write; free slots are never observed so they need no reset.
    always_ff @(posedge i_clk) begin
        if (push_en)
            mem[wr_ptr] <= i_data;
    end

    // Pointer/occupancy update; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_en)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_driver.sv
// alu_op_driver: initiator for the ALU operand interface. Accepts one command
// at a time, holds it on the ALU inputs, waits LAT clocks, captures the ALU
// result/status verbatim and queues it for the consumer.
// Optional feature macro: ALU_DRV_STICKY_STATUS_EN (OR-accumulated status).
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int M     = ALU_M,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [N-1:0]        i_cmd_op,
    input  logic [M-1:0]        i_cmd_A,
    input  logic [M-1:0]        i_cmd_B,
    output logic [N-1:0]        o_alu_op,
    output logic [M-1:0]        o_alu_A,
    output logic [M-1:0]        o_alu_B,
    input  logic [M-1:0]        i_alu_result,
    input  logic [ALU_ST_W-1:0] i_alu_status,
    output logic                o_resp_valid,
    input  logic                i_resp_ready,
    output logic [M-1:0]        o_resp_result,
    output logic [ALU_ST_W-1:0] o_resp_status,
    output logic                o_busy
`ifdef ALU_DRV_STICKY_STATUS_EN
    ,
    input  logic                i_sticky_clr,
    output logic [ALU_ST_W-1:0] o_sticky_status
`endif
);
    localparam int RW = M + ALU_ST_W;
    localparam int CW = $clog2(DEPTH+1);

    drv_state_e           state;
    drv_state_e           state_nxt;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 accept;
    logic                 capture;
    logic [RW-1:0]        fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full_unused;

    // Ready depends only on registered state; the slot for the response is
    // reserved here, so the capture push can never overflow.
    assign o_cmd_ready = (state == IDLE) && (fifo_count < CW'(DEPTH));
    assign accept      = i_cmd_valid && o_cmd_ready;
    // lat_cnt counts WAIT edges already taken; capture on the LAT-th one.
    assign capture     = (state == WAIT) && (lat_cnt == LAT_CNT_W'(LAT - 1));
    assign o_busy      = (state == WAIT);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: one command outstanding, back to IDLE on capture.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: cleared on accept, advances every WAIT edge.
    always_ff @(posedge i_clk) begin
        if (i_reset || accept || capture)
            lat_cnt <= '0;
        else if (state == WAIT)
            lat_cnt <= lat_cnt + LAT_CNT_W'(1);
    end

    // ALU operand registers: loaded on accept, held until the next accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_op <= '0;
            o_alu_A  <= '0;
            o_alu_B  <= '0;
        end else if (accept) begin
            o_alu_op <= i_cmd_op;
            o_alu_A  <= i_cmd_A;
            o_alu_B  <= i_cmd_B;
        end
    end

    // Full is implied by the count check above; left for other FIFO users.
    alu_resp_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (capture),
        .i_data  ({i_alu_result, i_alu_status}),
        .i_pop   (i_resp_ready),
        .o_head  (fifo_head),
        .o_count (fifo_count),
        .o_full  (fifo_full_unused),
        .o_empty (fifo_empty)
    );

    assign o_resp_valid  = !fifo_empty;
    assign o_resp_result = fifo_head[RW-1:ALU_ST_W];
    assign o_resp_status = fifo_head[ALU_ST_W-1:0];

`ifdef ALU_DRV_STICKY_STATUS_EN
    // Sticky status: OR of every captured status; clear beats same-cycle OR.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_sticky_clr)
            o_sticky_status <= '0;
        else if (capture)
            o_sticky_status <= o_sticky_status | i_alu_status;
    end
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: randomized bench for alu_op_driver with a behavioural ALU
// (latency LAT) and a queue-based reference model of the driver.
module tb_alu_op_driver;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int M = 8;
    localparam int LAT = 2;
    localparam int DEPTH = 4;

    logic i_clk, i_reset, i_cmd_valid, o_cmd_ready, i_resp_ready, o_resp_valid, o_busy;
    logic [N-1:0] i_cmd_op, o_alu_op;
    logic [M-1:0] i_cmd_A, i_cmd_B, o_alu_A, o_alu_B, i_alu_result, o_resp_result;
    logic [3:0] i_alu_status, o_resp_status;
`ifdef ALU_DRV_STICKY_STATUS_EN
    logic i_sticky_clr;
    logic [3:0] o_sticky_status;
`endif

    int passed = 0;
    int total = 0;

    alu_op_driver #(.N(N), .M(M), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_A(i_cmd_A), .i_cmd_B(i_cmd_B),
        .o_alu_op(o_alu_op), .o_alu_A(o_alu_A), .o_alu_B(o_alu_B),
        .i_alu_result(i_alu_result), .i_alu_status(i_alu_status),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_result(o_resp_result), .o_resp_status(o_resp_status),
        .o_busy(o_busy)
`ifdef ALU_DRV_STICKY_STATUS_EN
        , .i_sticky_clr(i_sticky_clr), .o_sticky_status(o_sticky_status)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural ALU: {result, status} from the operands.
    function automatic logic [11:0] alu_ref(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        logic [7:0] r;
        logic [7:0] neg;
        logic [3:0] s;
        neg = -a;
        case (op)
            OP_A_SUB_2B:  r = a - {b[6:0], 1'b0};
            OP_A_LT_B:    r = {7'd0, (a < b)};
            OP_SUM_BIT_B: r = 8'($countones(b));
            default:      r = a[7] ? {1'b1, neg[6:0]} : a;
        endcase
        s = 4'b0000;
        s[ST_ZERO]  = (r == 8'd0);
        s[ST_NEG]   = r[7];
        s[ST_CARRY] = ^r;
        s[ST_OVF]   = (op == OP_A_LT_B) && r[0];
        return {r, s};
    endfunction

    // ALU result valid LAT-1 register stages after the operands (LAT == 2).
    logic [11:0] alu_d1 = 12'd0;
    always @(posedge i_clk) alu_d1 <= alu_ref(o_alu_op, o_alu_A, o_alu_B);
    assign {i_alu_result, i_alu_status} = alu_d1;

    // Reference model state.
    logic [11:0] m_q[$];
    bit          m_inflight = 0;
    int          m_rem = 0;
    logic [11:0] m_pend = '0;
    logic [1:0]  m_op = '0;
    logic [7:0]  m_a = '0, m_b = '0;
    int          m_acc = 0;
    logic [3:0]  m_sticky = '0;

    logic [32:0] obs;
    assign obs = {o_cmd_ready, o_busy, o_resp_valid, o_resp_result, o_resp_status, o_alu_op, o_alu_A, o_alu_B};

    function automatic logic [32:0] model_vec();
        logic [11:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 12'd0;
        return {(!m_inflight && (m_q.size() < DEPTH)), m_inflight, (m_q.size() > 0), h, m_op, m_a, m_b};
    endfunction

    // Advance the model from the current inputs, then step one clock.
    task automatic tick();
        bit rdy;
        rdy = !m_inflight && (m_q.size() < DEPTH);
        if (i_reset) begin
            m_q.delete(); m_inflight = 0; m_op = '0; m_a = '0; m_b = '0; m_sticky = '0;
        end else begin
`ifdef ALU_DRV_STICKY_STATUS_EN
            if (i_sticky_clr) m_sticky = '0;
            else if (m_inflight && m_rem == 1) m_sticky = m_sticky | m_pend[3:0];
`endif
            if (i_resp_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (m_inflight) begin
                m_rem--;
                if (m_rem == 0) begin m_q.push_back(m_pend); m_inflight = 0; end
            end else if (i_cmd_valid && rdy) begin
                m_inflight = 1; m_rem = LAT; m_acc++;
                m_pend = alu_ref(i_cmd_op, i_cmd_A, i_cmd_B);
                m_op = i_cmd_op; m_a = i_cmd_A; m_b = i_cmd_B;
            end
        end
        @(posedge i_clk); #1;
    endtask

    task automatic drain();
        i_cmd_valid = 0; i_resp_ready = 1;
        for (int c = 0; c < 40 && (m_inflight || m_q.size() > 0); c++) tick();
        total++;
        if (o_resp_valid !== 1'b0 || o_busy !== 1'b0) $display("FAIL drain_timeout valid=%b busy=%b want 0 0", o_resp_valid, o_busy);
        else passed++;
        i_resp_ready = 0;
    endtask

    task automatic test_reset();
        i_reset = 1; tick(); tick();
        total++; if (obs !== model_vec()) $display("FAIL reset_hold got=%h exp=%h", obs, model_vec()); else passed++;
        total++;
        if ({o_alu_op, o_alu_A, o_alu_B, o_resp_valid, o_resp_result, o_resp_status, o_busy} !== '0)
            $display("FAIL reset_zero got=%h want 0", {o_alu_op, o_alu_A, o_alu_B, o_resp_valid, o_resp_result, o_resp_status, o_busy});
        else passed++;
        i_reset = 0; tick();
        total++; if (o_cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b want 1", o_cmd_ready); else passed++;
    endtask

    task automatic test_basic();
        i_resp_ready = 1;
        i_cmd_valid = 1; i_cmd_op = 2'b00; i_cmd_A = 8'h0A; i_cmd_B = 8'h03;
        tick();
        i_cmd_valid = 0; i_cmd_A = 8'hFF; i_cmd_B = 8'hFF;
        total++;
        if ({o_alu_op, o_alu_A, o_alu_B, o_busy} !== {2'b00, 8'h0A, 8'h03, 1'b1})
            $display("FAIL basic_operands got=%h want %h", {o_alu_op, o_alu_A, o_alu_B, o_busy}, {2'b00, 8'h0A, 8'h03, 1'b1});
        else passed++;
        for (int k = 1; k < LAT; k++) begin
            tick();
            total++; if (o_resp_valid !== 1'b0) $display("FAIL basic_early k=%0d valid=%b want 0", k, o_resp_valid); else passed++;
        end
        tick();
        total++;
        if (o_resp_valid !== 1'b1 || o_resp_result !== 8'h04 || obs !== model_vec())
            $display("FAIL basic_resp valid=%b result=%h want 1 04 (obs=%h exp=%h)", o_resp_valid, o_resp_result, obs, model_vec());
        else passed++;
        drain();
    endtask

    task automatic test_hold();
        i_resp_ready = 0;
        i_cmd_valid = 1; i_cmd_op = 2'b11; i_cmd_A = 8'hFB; i_cmd_B = 8'h00;
        tick();
        i_cmd_valid = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            total++; if (obs !== model_vec()) $display("FAIL hold_cyc%0d got=%h exp=%h", k, obs, model_vec()); else passed++;
        end
        total++;
        if (o_resp_valid !== 1'b1 || o_resp_result !== 8'h85) $display("FAIL hold_resp valid=%b result=%h want 1 85", o_resp_valid, o_resp_result);
        else passed++;
        i_resp_ready = 1; tick(); i_resp_ready = 0;
        total++; if (o_resp_valid !== 1'b0) $display("FAIL hold_pop valid=%b want 0", o_resp_valid); else passed++;
    endtask

    task automatic test_full();
        int acc0;
        acc0 = m_acc;
        i_resp_ready = 0;
        for (int c = 0; c < 40 && !((m_acc - acc0) == 4 && !m_inflight); c++) begin
            i_cmd_valid = 1; i_cmd_op = 2'($urandom); i_cmd_A = 8'($urandom); i_cmd_B = 8'($urandom);
            tick();
            total++; if (obs !== model_vec()) $display("FAIL full_fill got=%h exp=%h", obs, model_vec()); else passed++;
        end
        total++; if (o_cmd_ready !== 1'b0) $display("FAIL full_ready got=%b want 0", o_cmd_ready); else passed++;
        for (int c = 0; c < 5; c++) begin
            i_cmd_op = 2'($urandom); i_cmd_A = 8'($urandom); i_cmd_B = 8'($urandom);
            tick();
            total++; if (obs !== model_vec()) $display("FAIL full_blocked got=%h exp=%h", obs, model_vec()); else passed++;
        end
        i_resp_ready = 1; tick(); i_resp_ready = 0;
        for (int c = 0; c < 10 && (m_acc - acc0) < 5; c++) begin
            tick();
            total++; if (obs !== model_vec()) $display("FAIL full_fifth got=%h exp=%h", obs, model_vec()); else passed++;
        end
        i_cmd_valid = 0;
        total++; if ((m_acc - acc0) != 5 || o_busy !== 1'b1) $display("FAIL full_accept5 accepted=%0d busy=%b want 5 1", m_acc - acc0, o_busy); else passed++;
        i_resp_ready = 1;
        for (int c = 0; c < 20 && (m_inflight || m_q.size() > 0); c++) begin
            tick();
            total++; if (obs !== model_vec()) $display("FAIL full_drain got=%h exp=%h", obs, model_vec()); else passed++;
        end
        drain();
    endtask

    task automatic test_push_pop_full();
        i_resp_ready = 0;
        for (int c = 0; c < 60 && (m_q.size() < DEPTH - 1 || !m_inflight); c++) begin
            i_cmd_valid = 1; i_cmd_op = 2'($urandom); i_cmd_A = 8'($urandom); i_cmd_B = 8'($urandom);
            tick();
        end
        i_cmd_valid = 0;
        // pop exactly on the edge that pushes the last reserved entry
        for (int c = 0; c < 20 && m_inflight; c++) begin
            i_resp_ready = (m_rem == 1);
            tick();
            total++; if (obs !== model_vec()) $display("FAIL pushpop got=%h exp=%h", obs, model_vec()); else passed++;
        end
        i_resp_ready = 0;
        total++; if (o_cmd_ready !== 1'b1 || o_resp_valid !== 1'b1) $display("FAIL pushpop_state ready=%b valid=%b want 1 1", o_cmd_ready, o_resp_valid); else passed++;
        i_resp_ready = 1;
        for (int c = 0; c < 10 && m_q.size() > 0; c++) begin
            tick();
            total++; if (obs !== model_vec()) $display("FAIL pushpop_order got=%h exp=%h", obs, model_vec()); else passed++;
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_cmd_valid = ($urandom_range(0, 3) != 0);
            i_resp_ready = ($urandom_range(0, 2) == 0);
            i_cmd_op = 2'($urandom); i_cmd_A = 8'($urandom); i_cmd_B = 8'($urandom);
            tick();
            total++; if (obs !== model_vec()) $display("FAIL random_c%0d got=%h exp=%h", c, obs, model_vec()); else passed++;
        end
        drain();
    endtask

    task automatic test_reset_mid_wait();
        i_resp_ready = 1;
        i_cmd_valid = 1; i_cmd_op = 2'b10; i_cmd_A = 8'h12; i_cmd_B = 8'h5A;
        tick();
        i_cmd_valid = 0;
        i_reset = 1; tick(); i_reset = 0;
        total++; if (o_busy !== 1'b0 || obs !== model_vec()) $display("FAIL midreset busy=%b got=%h exp=%h", o_busy, obs, model_vec()); else passed++;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            total++; if (o_resp_valid !== 1'b0 || obs !== model_vec()) $display("FAIL midreset_noresp k=%0d valid=%b want 0", k, o_resp_valid); else passed++;
        end
    endtask

`ifdef ALU_DRV_STICKY_STATUS_EN
    task automatic test_sticky();
        i_sticky_clr = 0;
        i_reset = 1; tick(); i_reset = 0;
        total++; if (o_sticky_status !== 4'b0000) $display("FAIL sticky_reset got=%b want 0000", o_sticky_status); else passed++;
        i_cmd_valid = 1; i_cmd_op = 2'b00; i_cmd_A = 8'h06; i_cmd_B = 8'h03;
        tick(); drain();
        i_cmd_valid = 1; i_cmd_op = 2'b00; i_cmd_A = 8'h81; i_cmd_B = 8'h00;
        tick(); drain();
        total++;
        if (o_sticky_status !== 4'b0011 || o_sticky_status !== m_sticky) $display("FAIL sticky_or got=%b want 0011", o_sticky_status);
        else passed++;
        i_sticky_clr = 1; tick(); i_sticky_clr = 0;
        total++; if (o_sticky_status !== 4'b0000) $display("FAIL sticky_clr got=%b want 0000", o_sticky_status); else passed++;
    endtask
`endif

    initial begin
        i_reset = 1; i_cmd_valid = 0; i_resp_ready = 0;
        i_cmd_op = '0; i_cmd_A = '0; i_cmd_B = '0;
`ifdef ALU_DRV_STICKY_STATUS_EN
        i_sticky_clr = 0;
`endif
        test_reset();
        test_basic();
        test_hold();
        test_full();
        test_push_pop_full();
        test_random();
        test_reset_mid_wait();
`ifdef ALU_DRV_STICKY_STATUS_EN
        test_sticky();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
